// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {pc, inst} pairs with flush.
// Head reads as all-zero whenever the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 din,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  entry_t        mem [DEPTH];

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count==0 already masks stale contents at the head.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues sequential IM reads ahead of decode into a
// credit-limited queue, so every IM response is guaranteed a free slot.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   IM_req,
  output logic [ADDR_W-1:0]      IM_r_addr,
  input  logic [INST_W-1:0]      IM_r_data,
  output logic                   IF_valid,
  input  logic                   DC_ready,
  output logic [ADDR_W-1:0]      IF_out_pc,
  output logic [INST_W-1:0]      IF_out_inst,
  output logic [$clog2(DEPTH):0] IF_count
);

  localparam int CW = $clog2(DEPTH) + 2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic              inflight_valid;
  logic [ADDR_W-1:0] inflight_pc;
  logic              push;
  logic              pop;
  logic [CW-1:0]     credit_used;
  entry_t            head;
  entry_t            din;

  assign IF_valid = (IF_count != '0) && !redirect;
  assign pop      = IF_valid && DC_ready;
  assign push     = inflight && inflight_valid && !redirect;

  // Slots committed after this cycle; pop implies count >= 1, so no underflow.
  assign credit_used = CW'(IF_count) + CW'(inflight) - CW'(pop);

  // rst_n gates the request so IM sees no read while reset is held.
  assign IM_req    = rst_n && (redirect || (credit_used < CW'(DEPTH)));
  assign IM_r_addr = redirect ? redirect_pc : fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else if (IM_req) begin
      fetch_pc       <= IM_r_addr + ADDR_W'(PC_STEP);
      inflight       <= 1'b1;
      inflight_valid <= 1'b1;
      inflight_pc    <= IM_r_addr;
    end else begin
      inflight       <= 1'b0;
      inflight_valid <= 1'b0;
    end
  end

  assign din = '{pc: inflight_pc, inst: IM_r_data};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .head  (head),
    .count (IF_count)
  );

  assign IF_out_pc   = head.pc;
  assign IF_out_inst = head.inst;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: an IM model returning word = address,
// a cycle-by-cycle vector table, and hand-written reset sequences.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        im_req;
  logic [31:0] im_r_addr;
  logic [31:0] im_r_data = '0;
  logic        if_valid;
  logic        dc_ready = 1'b0;
  logic [31:0] if_out_pc;
  logic [31:0] if_out_inst;
  logic [2:0]  if_count;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic        dc_ready;
    logic        redirect;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  if_fetch_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .IM_req      (im_req),
    .IM_r_addr   (im_r_addr),
    .IM_r_data   (im_r_data),
    .IF_valid    (if_valid),
    .DC_ready    (dc_ready),
    .IF_out_pc   (if_out_pc),
    .IF_out_inst (if_out_inst),
    .IF_count    (if_count)
  );

  always #5 clk = ~clk;

  // IM model: one-cycle read latency, word equals address; garbage when idle.
  always @(posedge clk) im_r_data <= im_req ? im_r_addr : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic dr, input logic rd, input logic [31:0] rpc,
                     input logic req, input logic [31:0] addr, input logic v,
                     input logic [31:0] pc, input logic [31:0] inst, input logic [2:0] cnt);
    vecs.push_back('{dr, rd, rpc, req, addr, v, pc, inst, cnt});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   {31'b0, im_req},   32'h0);
    check({tag, ".addr"},  im_r_addr,         32'h0);
    check({tag, ".valid"}, {31'b0, if_valid}, 32'h0);
    check({tag, ".pc"},    if_out_pc,         32'h0);
    check({tag, ".inst"},  if_out_inst,       32'h0);
    check({tag, ".count"}, {29'b0, if_count}, 32'h0);
  endtask

  initial begin
    int pulses;

    // Streaming from reset, then back-pressure, then redirects (incl. wrap).
    add(1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 32'h8,        1, 32'h0,        32'h0,        1);
    add(1, 0, 32'h0,        1, 32'hC,        1, 32'h4,        32'h4,        1);
    add(1, 0, 32'h0,        1, 32'h10,       1, 32'h8,        32'h8,        1);
    add(0, 0, 32'h0,        1, 32'h14,       1, 32'hC,        32'hC,        1);
    add(0, 0, 32'h0,        1, 32'h18,       1, 32'hC,        32'hC,        2);
    add(0, 0, 32'h0,        0, 32'h1C,       1, 32'hC,        32'hC,        3);
    add(0, 0, 32'h0,        0, 32'h1C,       1, 32'hC,        32'hC,        4);
    add(0, 0, 32'h0,        0, 32'h1C,       1, 32'hC,        32'hC,        4);
    add(1, 0, 32'h0,        1, 32'h1C,       1, 32'hC,        32'hC,        4);
    add(1, 0, 32'h0,        1, 32'h20,       1, 32'h10,       32'h10,       3);
    add(1, 0, 32'h0,        1, 32'h24,       1, 32'h14,       32'h14,       3);
    add(1, 1, 32'h100,      1, 32'h100,      0, 32'h18,       32'h18,       3);
    add(1, 0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 32'h108,      1, 32'h100,      32'h100,      1);
    add(1, 0, 32'h0,        1, 32'h10C,      1, 32'h104,      32'h104,      1);
    add(1, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h108,      32'h108,      1);
    add(1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        1, 32'h4,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1);
    add(1, 0, 32'h0,        1, 32'h8,        1, 32'h0,        32'h0,        1);

    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      dc_ready    = vecs[i].dc_ready;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      @(negedge clk);
      check($sformatf("v%0d.req", i),   {31'b0, im_req},   {31'b0, vecs[i].req});
      check($sformatf("v%0d.addr", i),  im_r_addr,         vecs[i].addr);
      check($sformatf("v%0d.valid", i), {31'b0, if_valid}, {31'b0, vecs[i].valid});
      check($sformatf("v%0d.pc", i),    if_out_pc,         vecs[i].pc);
      check($sformatf("v%0d.inst", i),  if_out_inst,       vecs[i].inst);
      check($sformatf("v%0d.count", i), {29'b0, if_count}, {29'b0, vecs[i].cnt});
      @(posedge clk); #1;
    end
    redirect    = 1'b0;
    redirect_pc = '0;

    // Back-pressure from reset: exactly DEPTH requests, then the queue sits full.
    dc_ready = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (im_req) pulses++;
      @(posedge clk); #1;
    end
    check("bp.pulses", pulses, 32'd4);
    check("bp.count",  {29'b0, if_count}, 32'd4);
    check("bp.addr",   im_r_addr, 32'h10);
    check("bp.head",   if_out_pc, 32'h0);

    // Asynchronous reset mid-cycle while full: outputs clear before the next edge.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n    = 1'b1;
    dc_ready = 1'b1;
    @(negedge clk);
    check("restart.req",  {31'b0, im_req}, 32'h1);
    check("restart.addr", im_r_addr,       32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a decoupling queue between instruction memory (IM) and the DC stage. It issues sequential IM reads ahead of decode, holds up to DEPTH fetched {pc, inst} pairs, and flushes on a redirect from EXE/IS. It replaces the single-entry skid buffer with a credit-limited queue, so IM never returns data that has no room to land.

## Interface

Parameters:
- ADDR_W, 32, PC / IM address width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect  in  1  flush and restart fetch at redirect_pc (mispredict)
- redirect_pc  in  ADDR_W  restart address
- IM_req  out  1  IM read enable this cycle
- IM_r_addr  out  ADDR_W  IM read address
- IM_r_data  in  INST_W  IM data, valid exactly 1 cycle after an accepted IM_req
- IF_valid  out  1  queue head valid to DC
- DC_ready  in  1  DC accepts head
- IF_out_pc  out  ADDR_W  head PC
- IF_out_inst  out  INST_W  head instruction
- IF_count  out  $clog2(DEPTH)+1  queue occupancy

## Operation

- State: fetch_pc, queue (count), inflight (1 bit: request issued last cycle), inflight_valid (response not flushed).
- pop = IF_valid & DC_ready & !redirect.
- Issue rule: IM_req = redirect | (count + inflight - pop < DEPTH); all arithmetic in $clog2(DEPTH)+2 bits, no underflow.
- IM_r_addr = redirect ? redirect_pc : fetch_pc.
- Accepted issue: fetch_pc <= IM_r_addr + 4, wraps mod 2^ADDR_W; inflight <= 1, tagged with its PC.
- No issue: fetch_pc holds, inflight <= 0.
- Response cycle: if inflight & inflight_valid & !redirect, push {tagged pc, IM_r_data}.
- Redirect: queue emptied (count <= 0), response arriving this cycle dropped, IF_valid forced 0 this cycle, new request issued same cycle at redirect_pc.
- Push and pop in the same cycle: count unchanged; the credit rule guarantees no push into a full queue.
- Empty queue: IF_valid=0, IF_out_pc=0, IF_out_inst=0.
- Head outputs are registered queue contents; no combinational bypass from IM_r_data.

## Timing

- Reset (asynchronous on rst_n low): fetch_pc=RESET_PC, count=0, inflight=0, IM_req=0, IM_r_addr=RESET_PC, IF_valid=0, IF_out_pc=0, IF_out_inst=0, IF_count=0.
- First IM_req=1 in the first cycle after rst_n rises.
- Latency: request in cycle N -> data pushed at end of N+1 -> IF_valid in N+2.
- Steady state with DC_ready=1: one instruction per cycle, IM_req continuously 1.
- DC_ready low: at most DEPTH entries held; IM_req drops once count+inflight reaches DEPTH and rises in the same cycle DC_ready returns.
- IM_req depends combinationally on DC_ready and redirect; documented as an intended path.
- Redirect in cycle R: first post-redirect instruction (pc=redirect_pc) valid in R+2.
- rst_n asserted mid-stream discards queue and inflight immediately.

## Structure

- fetch_pkg: fetch_entry_t struct {pc, inst}, PC_STEP = 4.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, head; asynchronous active-low reset; zero head when empty.
- Top level holds fetch_pc, inflight tracking, issue/credit logic.

## Test plan

- Reset release, DC_ready=1, IM returns word = address: IM_r_addr 0,4,8,…; IF_valid first high in cycle 2 with pc=0, inst=0; one entry per cycle thereafter.
- DEPTH=4, DC_ready=0 from reset: exactly 4 IM_req pulses, IF_count=4, IM_req=0 afterwards; DC_ready=1 resumes at pc=0x10 with no loss or duplication.
- Redirect to 0x100 with 3 entries queued and one inflight: next cycle IF_count=0, stale response not pushed; IF_valid at R+2 with pc=0x100, then 0x104.
- Redirect and DC_ready=1 on the same cycle: no pop, IF_valid=0 that cycle, queue flushed.
- fetch_pc = 2^ADDR_W-4: next address wraps to 0.
- rst_n low while queue full: outputs return to reset values asynchronously, before the next clock edge.
